// File: rtl/counter_pkg.sv
// Shared types for the counter bank: counting mode and width helper.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP     = 1'b0,
    CNT_SATURATE = 1'b1
  } cnt_mode_e;

  // Largest value representable in w bits, used for MAX_COUNT defaults and range checks.
  function automatic longint unsigned max_for_width(input int unsigned w);
    return (longint'(1) << w) - 1;
  endfunction

endpackage

// File: rtl/counter_lane.sv
// One up/down counter lane with clear/load, terminal-count pulse and sticky overflow.
// Latency: one clock from inputs to o_count, o_tc and o_ovf; all outputs registered.
module counter_lane
  import counter_pkg::*;
#(
  parameter int        WIDTH     = 10,
  parameter int        MAX_COUNT = 2**WIDTH - 1,
  parameter cnt_mode_e MODE      = CNT_WRAP
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_evt;

  always_comb begin
    count_nxt = o_count;
    tc_nxt    = 1'b0;
    ovf_evt   = 1'b0;
    if (i_clear) begin
      count_nxt = '0;
    end else if (i_load) begin
      count_nxt = (i_load_val > MAX) ? MAX : i_load_val;
    end else if (i_en) begin
      if (i_up) begin
        if (o_count >= MAX) begin
          ovf_evt = 1'b1;
          if (MODE == CNT_WRAP) begin
            count_nxt = '0;
            tc_nxt    = 1'b1;
          end
        end else begin
          count_nxt = o_count + ONE;
          // In saturate mode, arriving at the rail is the terminal event.
          tc_nxt    = (MODE == CNT_SATURATE) && (count_nxt == MAX);
        end
      end else begin
        if (o_count == '0) begin
          ovf_evt = 1'b1;
          if (MODE == CNT_WRAP) begin
            count_nxt = MAX;
            tc_nxt    = 1'b1;
          end
        end else begin
          count_nxt = o_count - ONE;
          tc_nxt    = (MODE == CNT_SATURATE) && (count_nxt == '0);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
      o_tc    <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_count <= count_nxt;
      o_tc    <= tc_nxt;
      // A new event beats a simultaneous clear so no overflow is lost.
      o_ovf   <= ovf_evt | (o_ovf & ~i_ovf_clr);
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent up/down counter lanes with packed load/count vectors.
// Latency: one clock from inputs to every output; no combinational input-to-output path.
module counter_bank
  import counter_pkg::*;
#(
  parameter int        CHANNELS  = 4,
  parameter int        WIDTH     = 10,
  parameter int        MAX_COUNT = 2**WIDTH - 1,
  parameter cnt_mode_e MODE      = CNT_WRAP
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS-1:0]       i_en,
  input  logic [CHANNELS-1:0]       i_up,
  input  logic [CHANNELS-1:0]       i_clear,
  input  logic [CHANNELS-1:0]       i_load,
  input  logic [CHANNELS*WIDTH-1:0] i_load_val,
  input  logic [CHANNELS-1:0]       i_ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] o_count,
  output logic [CHANNELS-1:0]       o_tc,
  output logic [CHANNELS-1:0]       o_ovf
);

  generate
    if (CHANNELS < 1 || WIDTH < 2 || MAX_COUNT < 1 ||
        longint'(MAX_COUNT) > longint'(max_for_width(WIDTH))) begin : g_bad_params
      $error("counter_bank: need CHANNELS>=1, WIDTH>=2, 1<=MAX_COUNT<=2**WIDTH-1");
    end
  endgenerate

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    counter_lane #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .MODE      (MODE)
    ) u_lane (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en[k]),
      .i_up       (i_up[k]),
      .i_clear    (i_clear[k]),
      .i_load     (i_load[k]),
      .i_load_val (i_load_val[k*WIDTH +: WIDTH]),
      .i_ovf_clr  (i_ovf_clr[k]),
      .o_count    (o_count[k*WIDTH +: WIDTH]),
      .o_tc       (o_tc[k]),
      .o_ovf      (o_ovf[k])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench: a wrap and a saturate bank (4 lanes, 4 bits, terminal 9) on shared stimulus.
module tb_counter_bank;
  import counter_pkg::*;

  localparam int CH  = 4;
  localparam int W   = 4;
  localparam int MAX = 9;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   en, up, clear, load, ovf_clr;
  logic [CH*W-1:0] load_val;
  logic [CH*W-1:0] cnt_w, cnt_s;
  logic [CH-1:0]   tc_w, tc_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = wrap bank, 1 = saturate bank.
  int m_cnt [2][CH];
  bit m_tc  [2][CH];
  bit m_ovf [2][CH];

  counter_bank #(.CHANNELS(CH), .WIDTH(W), .MAX_COUNT(MAX), .MODE(CNT_WRAP)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_clear(clear), .i_load(load),
    .i_load_val(load_val), .i_ovf_clr(ovf_clr), .o_count(cnt_w), .o_tc(tc_w), .o_ovf(ovf_w)
  );

  counter_bank #(.CHANNELS(CH), .WIDTH(W), .MAX_COUNT(MAX), .MODE(CNT_SATURATE)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_clear(clear), .i_load(load),
    .i_load_val(load_val), .i_ovf_clr(ovf_clr), .o_count(cnt_s), .o_tc(tc_s), .o_ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lane_of(input logic [CH*W-1:0] v, input int k);
    return int'(v[k*W +: W]);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < CH; k++) begin
        m_cnt[m][k] = 0; m_tc[m][k] = 0; m_ovf[m][k] = 0;
      end
  endtask

  // Behaviour from the rules, in plain integer arithmetic.
  task automatic model_step();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < CH; k++) begin
        bit evt = 0;
        int n;
        m_tc[m][k] = 0;
        if (clear[k]) m_cnt[m][k] = 0;
        else if (load[k]) m_cnt[m][k] = (lane_of(load_val, k) > MAX) ? MAX : lane_of(load_val, k);
        else if (en[k]) begin
          n = up[k] ? m_cnt[m][k] + 1 : m_cnt[m][k] - 1;
          if (n > MAX || n < 0) begin
            evt = 1;
            if (m == 0) begin
              m_cnt[m][k] = (n > MAX) ? 0 : MAX;
              m_tc[m][k]  = 1;
            end
          end else begin
            m_cnt[m][k] = n;
            m_tc[m][k]  = (m == 1) && (n == (up[k] ? MAX : 0));
          end
        end
        if (evt) m_ovf[m][k] = 1;
        else if (ovf_clr[k]) m_ovf[m][k] = 0;
      end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    en = '0; up = '0; clear = '0; load = '0; ovf_clr = '0; load_val = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #12;
    rst_n = 1'b1;
    checks++;
    if (cnt_w !== '0 || cnt_s !== '0 || tc_w !== '0 || ovf_w !== '0 || tc_s !== '0 || ovf_s !== '0) begin
      errors++;
      $display("FAIL reset_init: cnt_w=%h cnt_s=%h tc=%b/%b ovf=%b/%b, required all 0",
               cnt_w, cnt_s, tc_w, tc_s, ovf_w, ovf_s);
    end
    en = '1; up = '1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (cnt_w !== '0 || cnt_s !== '0 || tc_w !== '0 || tc_s !== '0 || ovf_w !== '0 || ovf_s !== '0) begin
      errors++;
      $display("FAIL reset_async: cnt_w=%h cnt_s=%h, required 0 immediately", cnt_w, cnt_s);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cnt_w !== '0 || cnt_s !== '0) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d cnt_w=%h cnt_s=%h, required 0", i, cnt_w, cnt_s);
      end
    end
    #3;
    rst_n = 1'b1;
    tick();
    checks++;
    if (cnt_w !== 16'h1111 || cnt_s !== 16'h1111) begin
      errors++;
      $display("FAIL reset_restart: cnt_w=%h cnt_s=%h, required 1111", cnt_w, cnt_s);
    end
    set_idle();
  endtask

  task automatic clear_all();
    set_idle();
    clear = '1; ovf_clr = '1;
    tick();
    set_idle();
  endtask

  task automatic test_wrap_up();
    int exp;
    clear_all();
    en[0] = 1'b1; up[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp = i % 10;
      checks++;
      if (lane_of(cnt_w, 0) !== exp || tc_w[0] !== (exp == 0) || ovf_w[0] !== (i >= 10)) begin
        errors++;
        $display("FAIL wrap_up step %0d: cnt=%0d tc=%b ovf=%b, required cnt=%0d tc=%b ovf=%b",
                 i, lane_of(cnt_w, 0), tc_w[0], ovf_w[0], exp, exp == 0, i >= 10);
      end
    end
    checks++;
    if (cnt_w[CH*W-1:W] !== '0) begin
      errors++;
      $display("FAIL wrap_up_isolation: lanes1-3=%h, required 0", cnt_w[CH*W-1:W]);
    end
    set_idle();
  endtask

  task automatic test_wrap_down();
    int exp_c [3] = '{0, 9, 8};
    bit exp_t [3] = '{0, 1, 0};
    bit exp_o [3] = '{0, 1, 1};
    set_idle();
    load[0] = 1'b1; load_val[3:0] = 4'd1; ovf_clr[0] = 1'b1;
    tick();
    set_idle();
    en[0] = 1'b1; up[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (lane_of(cnt_w, 0) !== exp_c[i] || tc_w[0] !== exp_t[i] || ovf_w[0] !== exp_o[i]) begin
        errors++;
        $display("FAIL wrap_down step %0d: cnt=%0d tc=%b ovf=%b, required cnt=%0d tc=%b ovf=%b",
                 i, lane_of(cnt_w, 0), tc_w[0], ovf_w[0], exp_c[i], exp_t[i], exp_o[i]);
      end
    end
    set_idle();
  endtask

  task automatic test_saturate();
    int exp_c [4] = '{8, 9, 9, 9};
    bit exp_t [4] = '{0, 1, 0, 0};
    bit exp_o [4] = '{0, 0, 1, 1};
    set_idle();
    load[0] = 1'b1; load_val[3:0] = 4'd7; ovf_clr[0] = 1'b1;
    tick();
    set_idle();
    en[0] = 1'b1; up[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (lane_of(cnt_s, 0) !== exp_c[i] || tc_s[0] !== exp_t[i] || ovf_s[0] !== exp_o[i]) begin
        errors++;
        $display("FAIL saturate step %0d: cnt=%0d tc=%b ovf=%b, required cnt=%0d tc=%b ovf=%b",
                 i, lane_of(cnt_s, 0), tc_s[0], ovf_s[0], exp_c[i], exp_t[i], exp_o[i]);
      end
    end
    set_idle();
  endtask

  task automatic test_priority();
    set_idle();
    clear[0] = 1'b1; load[0] = 1'b1; load_val[3:0] = 4'd5; en[0] = 1'b1; up[0] = 1'b1;
    tick();
    checks++;
    if (lane_of(cnt_w, 0) !== 0 || lane_of(cnt_s, 0) !== 0) begin
      errors++;
      $display("FAIL prio_clear: cnt_w=%0d cnt_s=%0d, required 0", lane_of(cnt_w, 0), lane_of(cnt_s, 0));
    end
    set_idle();
    load[0] = 1'b1; load_val[3:0] = 4'd12; ovf_clr[0] = 1'b1; en[0] = 1'b1;
    tick();
    checks++;
    if (lane_of(cnt_w, 0) !== 9 || lane_of(cnt_s, 0) !== 9 || ovf_w[0] !== 1'b0 || ovf_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL prio_load_clamp: cnt_w=%0d cnt_s=%0d ovf=%b/%b, required 9 9 0 0",
               lane_of(cnt_w, 0), lane_of(cnt_s, 0), ovf_w[0], ovf_s[0]);
    end
    set_idle();
    en[0] = 1'b1; up[0] = 1'b1; ovf_clr[0] = 1'b1;
    tick();
    checks++;
    if (ovf_w[0] !== 1'b1 || ovf_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL prio_ovf_set_wins: ovf_w=%b ovf_s=%b, required 1 1", ovf_w[0], ovf_s[0]);
    end
    set_idle();
    ovf_clr[0] = 1'b1;
    tick();
    checks++;
    if (ovf_w[0] !== 1'b0 || ovf_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf_w=%b ovf_s=%b, required 0 0", ovf_w[0], ovf_s[0]);
    end
    set_idle();
  endtask

  task automatic test_independence();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < CH; k++) begin
        en[k]      = ($urandom_range(0, 3) != 0);
        up[k]      = $urandom_range(0, 1) == 1;
        clear[k]   = ($urandom_range(0, 31) == 0);
        load[k]    = ($urandom_range(0, 15) == 0);
        ovf_clr[k] = ($urandom_range(0, 7) == 0);
        load_val[k*W +: W] = W'($urandom_range(0, 15));
      end
      tick();
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (lane_of(cnt_w, k) !== m_cnt[0][k] || tc_w[k] !== m_tc[0][k] || ovf_w[k] !== m_ovf[0][k]) begin
          errors++;
          $display("FAIL rand_wrap cyc %0d lane %0d: cnt=%0d tc=%b ovf=%b, required cnt=%0d tc=%b ovf=%b",
                   c, k, lane_of(cnt_w, k), tc_w[k], ovf_w[k], m_cnt[0][k], m_tc[0][k], m_ovf[0][k]);
        end
        checks++;
        if (lane_of(cnt_s, k) !== m_cnt[1][k] || tc_s[k] !== m_tc[1][k] || ovf_s[k] !== m_ovf[1][k]) begin
          errors++;
          $display("FAIL rand_sat cyc %0d lane %0d: cnt=%0d tc=%b ovf=%b, required cnt=%0d tc=%b ovf=%b",
                   c, k, lane_of(cnt_s, k), tc_s[k], ovf_s[k], m_cnt[1][k], m_tc[1][k], m_ovf[1][k]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_independence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
